// File: rtl/mii_net_pkg.sv
// -----------------------------------------------------------------------------
// mii_net_pkg
// Shared definitions for the MII receive path.
//   rx_state_e     : framer FSM states
//   CRC32_*        : reflected Ethernet CRC-32 constants
//   PRE_NIB/SFD_NIB: preamble and start-of-frame nibble values
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mii_net_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  // Register value left after running the CRC over data plus a correct FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

endpackage

// File: rtl/crc32_d8.sv
// -----------------------------------------------------------------------------
// crc32_d8
// Combinational next-state of the reflected CRC-32 for one byte, LSB first.
// Ports:
//   crc_i  [31:0] : current CRC register
//   byte_i [7:0]  : data byte
//   crc_o  [31:0] : CRC register after absorbing byte_i
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module crc32_d8
  import mii_net_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  // The byte is folded into the low bits up front; eight shift steps then
  // process it one bit at a time, LSB first.
  always_comb begin
    c = crc_i ^ {24'h0, byte_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/mii_rx_frame.sv
// -----------------------------------------------------------------------------
// mii_rx_frame
// MII receive framer: strips preamble/SFD, assembles nibbles into bytes,
// checks length and FCS, and reports per-frame status plus statistics.
// Ports:
//   enet_rx_clk        : PHY receive clock (rising edge)
//   i_reset            : synchronous active-high reset
//   enet_rx_dv         : MII receive data valid
//   enet_rx_data [3:0] : MII nibble, low nibble of each byte first
//   o_data [7:0]       : received byte, valid with o_valid
//   o_valid            : one-cycle byte strobe
//   o_sof              : first byte of a frame (with o_valid)
//   o_eof              : one-cycle end-of-frame strobe
//   o_good             : frame verdict, qualified by o_eof
//   o_len [10:0]       : frame byte count incl. FCS, qualified by o_eof
//   o_frame_count[31:0]: good frames, wrapping
//   o_err_count [15:0] : bad frames plus preamble errors, saturating
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mii_rx_frame
  import mii_net_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
)(
  input  logic        enet_rx_clk,
  input  logic        i_reset,
  input  logic        enet_rx_dv,
  input  logic [3:0]  enet_rx_data,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_good,
  output logic [10:0] o_len,
  output logic [31:0] o_frame_count,
  output logic [15:0] o_err_count
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  rx_state_e   state_q, state_d;
  logic [3:0]  lo_nib_q, lo_nib_d;
  logic        phase_q, phase_d;   // 1: a low nibble is held, waiting for its high nibble
  logic        first_q, first_d;   // next byte assembled is the first of the frame
  logic [31:0] crc_q, crc_d, crc_next;
  logic [10:0] len_q, len_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        good_q, good_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        drop_err;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'h0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .byte_i ({enet_rx_data, lo_nib_q}),
    .crc_o  (crc_next)
  );

  // ---- next-state / output decode ----
  always_comb begin
    state_d  = state_q;
    lo_nib_d = lo_nib_q;
    phase_d  = phase_q;
    first_d  = first_q;
    crc_d    = crc_q;
    len_d    = len_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    good_d   = 1'b0;
    drop_err = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enet_rx_dv) begin
          if (enet_rx_data == PRE_NIB) begin
            state_d = ST_PREAMBLE;
          end else begin
            state_d  = ST_DROP;
            drop_err = 1'b1;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!enet_rx_dv) begin
          state_d = ST_IDLE;
        end else if (enet_rx_data == SFD_NIB) begin
          state_d = ST_DATA;
          crc_d   = CRC32_INIT;
          len_d   = 11'd0;
          phase_d = 1'b0;
          first_d = 1'b1;
        end else if (enet_rx_data != PRE_NIB) begin
          state_d  = ST_DROP;
          drop_err = 1'b1;
        end
      end

      ST_DATA: begin
        if (!enet_rx_dv) begin
          // A held low nibble here means the frame ended mid-byte.
          state_d = ST_IDLE;
          eof_d   = 1'b1;
          good_d  = (crc_q == CRC32_RESIDUE) && (len_q >= MIN_L) &&
                    (len_q <= MAX_L) && !phase_q;
        end else if (!phase_q) begin
          lo_nib_d = enet_rx_data;
          phase_d  = 1'b1;
        end else begin
          data_d  = {enet_rx_data, lo_nib_q};
          valid_d = 1'b1;
          sof_d   = first_q;
          first_d = 1'b0;
          crc_d   = crc_next;
          len_d   = sat_inc11(len_q);
          phase_d = 1'b0;
        end
      end

      ST_DROP: begin
        if (!enet_rx_dv) state_d = ST_IDLE;
      end

      default: state_d = ST_DROP;
    endcase

    // An eof verdict and a fresh preamble error can land on the same edge.
    frame_cnt_d = frame_cnt_q + {31'h0, eof_q & good_q};
    err_cnt_d   = sat_add16(err_cnt_q,
                            {1'b0, eof_q & ~good_q} + {1'b0, drop_err});
  end

  // ---- registers ----
  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      state_q     <= ST_DROP;
      lo_nib_q    <= 4'h0;
      phase_q     <= 1'b0;
      first_q     <= 1'b0;
      crc_q       <= CRC32_INIT;
      len_q       <= 11'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      good_q      <= 1'b0;
      frame_cnt_q <= 32'h0;
      err_cnt_q   <= 16'h0;
    end else begin
      state_q     <= state_d;
      lo_nib_q    <= lo_nib_d;
      phase_q     <= phase_d;
      first_q     <= first_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      good_q      <= good_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_sof         = sof_q;
  assign o_eof         = eof_q;
  assign o_good        = good_q;
  assign o_len         = len_q;
  assign o_frame_count = frame_cnt_q;
  assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_mii_rx_frame.sv
`timescale 1ns/1ps
module tb_mii_rx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [3:0]  nib;
  logic [7:0]  o_data;
  logic        o_valid, o_sof, o_eof, o_good;
  logic [10:0] o_len;
  logic [31:0] o_frame_count;
  logic [15:0] o_err_count;

  always #5 clk = ~clk;

  mii_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .enet_rx_clk   (clk),
    .i_reset       (rst),
    .enet_rx_dv    (dv),
    .enet_rx_data  (nib),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_good        (o_good),
    .o_len         (o_len),
    .o_frame_count (o_frame_count),
    .o_err_count   (o_err_count)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0]  byte_exp[$];   // {sof, data}
  logic [11:0] eof_exp[$];    // {good, len}
  logic [7:0]  frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    logic [8:0]  be;
    logic [11:0] ee;
    if (o_valid || o_eof) check("valid_eof_overlap", {31'h0, o_valid & o_eof}, 32'h0);
    if (o_valid) begin
      if (byte_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_byte: got sof=%0b data=%02h expected none", o_sof, o_data);
      end else begin
        be = byte_exp.pop_front();
        check("byte", {23'h0, o_sof, o_data}, {23'h0, be});
      end
    end
    if (o_eof) begin
      if (eof_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_eof: got good=%0b len=%0d expected none", o_good, o_len);
      end else begin
        ee = eof_exp.pop_front();
        check("eof_good_len", {20'h0, o_good, o_len}, {20'h0, ee});
      end
    end
  end

  // Bit-serial reflected CRC-32 reference.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // Payload of n bytes (value = index mod 256) followed by its FCS.
  task automatic build(input int n);
    logic [31:0] c;
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'(i));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_step(c, frame_q[i]);
    fcs = ~c;
    frame_q.push_back(fcs[7:0]);
    frame_q.push_back(fcs[15:8]);
    frame_q.push_back(fcs[23:16]);
    frame_q.push_back(fcs[31:24]);
  endtask

  task automatic drive(input logic v, input logic [3:0] n);
    @(posedge clk); #1;
    dv  = v;
    nib = n;
  endtask

  task automatic send(input bit bad_pre, input bit dribble, input int rst_at,
                      input int gap, input bit exp_good, input int exp_len);
    if (bad_pre) begin
      drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'h3);
      for (int i = 0; i < 12; i++) drive(1'b1, 4'h5);
    end else begin
      for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    end
    drive(1'b1, 4'hD);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == rst_at) begin
        @(posedge clk); #1;
        rst = 1'b1; dv = 1'b1; nib = frame_q[i][3:0];
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_outputs", {12'h0, o_valid, o_sof, o_eof, o_good, o_len, o_data}, 32'h0);
        check("rst_mid_frames", o_frame_count, 32'h0);
        check("rst_mid_errs", {16'h0, o_err_count}, 32'h0);
        nib = frame_q[i][7:4];
      end else begin
        if (!bad_pre && (rst_at < 0 || i < rst_at))
          byte_exp.push_back({(i == 0), frame_q[i]});
        drive(1'b1, frame_q[i][3:0]);
        drive(1'b1, frame_q[i][7:4]);
      end
    end
    if (dribble) drive(1'b1, 4'hA);
    if (!bad_pre && rst_at < 0) eof_exp.push_back({exp_good, 11'(exp_len)});
    for (int i = 0; i < gap; i++) drive(1'b0, 4'h0);
  endtask

  task automatic check_counts(input string name, input int fc, input int ec);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_frames"}, o_frame_count, 32'(fc));
    check({name, "_errs"}, {16'h0, o_err_count}, 32'(ec));
    check({name, "_pending"}, 32'(byte_exp.size() + eof_exp.size()), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dv = 1'b0; nib = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {12'h0, o_valid, o_sof, o_eof, o_good, o_len, o_data}, 32'h0);
    check("reset_frames", o_frame_count, 32'h0);
    check("reset_errs", {16'h0, o_err_count}, 32'h0);
    rst = 1'b0;

    // Good 64-byte frame.
    build(60);
    send(0, 0, -1, 4, 1'b1, 64);
    check_counts("good", 1, 0);

    // Bit 0 of payload byte 10 flipped after FCS computed.
    build(60);
    frame_q[10] = frame_q[10] ^ 8'h01;
    send(0, 0, -1, 4, 1'b0, 64);
    check_counts("crc_err", 1, 1);

    // Runt, correct FCS.
    build(28);
    send(0, 0, -1, 4, 1'b0, 32);
    check_counts("runt", 1, 2);

    // One byte over maximum, correct FCS.
    build(1515);
    send(0, 0, -1, 4, 1'b0, 1519);
    check_counts("giant", 1, 3);

    // Preamble error: no output at all.
    build(60);
    send(1, 0, -1, 4, 1'b0, 0);
    check_counts("pre_err", 1, 4);

    // Clean frame, then a dribble frame after a single-cycle gap.
    build(60);
    send(0, 0, -1, 1, 1'b1, 64);
    build(60);
    send(0, 1, -1, 4, 1'b0, 64);
    check_counts("dribble", 2, 5);

    // Reset at byte 20 aborts the frame and clears counters.
    build(60);
    send(0, 0, 20, 4, 1'b0, 0);
    check_counts("rst_abort", 0, 0);

    build(60);
    send(0, 0, -1, 4, 1'b1, 64);
    check_counts("after_rst", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
